dpram_write_sched: RTL and testbench
====================================

DPRAM_WRITE_SCHED -- requirements
Module: dpram_write_sched

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 32, RAM word width.
- ADDR_WIDTH, 4, RAM address width; minimum 1.
- NUM_REQ, 4, number of write requesters; range 2..8.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high. Clock and reset ports SHALL be named ACLK and ARESET.
REQ-003 Ports SHALL be:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- REQ_VALID  in  NUM_REQ  per-requester write request.
- REQ_ADDR  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  flattened write data, sliced the same way.
- REQ_READY  out  NUM_REQ  per-requester grant (combinational).
- INIT_START  in  1  one-cycle pulse requesting RAM clear.
- INIT_BUSY  out  1  clear sequence in progress.
- PORTA_W_ADDR / PORTA_W_DATA / PORTA_W_EN  out  ADDR_WIDTH / DATA_WIDTH / 1  RAM port A write (registered).
- PORTB_W_ADDR / PORTB_W_DATA / PORTB_W_EN  out  ADDR_WIDTH / DATA_WIDTH / 1  RAM port B write (registered).
- PORTB_W_CONTENT  in  1  RAM same-address write-conflict flag.
- ERR  out  1  sticky protocol error.
- STALL_CNT  out  16  saturating count of stall cycles.

Function
REQ-004 A handshake on requester i SHALL occur in any cycle where REQ_VALID[i] and REQ_READY[i] are both 1.
REQ-005 FSM states SHALL be ARB and INIT:
- ARB to INIT when INIT_START=1.
- INIT to ARB at the edge where clear counter C equals 2^(ADDR_WIDTH-1)-1.
- INIT_START SHALL be ignored while in INIT.
REQ-006 In INIT, REQ_READY SHALL be all 0 and INIT_BUSY SHALL be 1. In ARB, INIT_BUSY SHALL be 0.
REQ-007 In ARB, arbitration SHALL scan requesters starting at round-robin pointer PTR, ascending modulo NUM_REQ:
- The first valid requester is granted to port A.
- The next valid requester whose address differs from the port A winner is granted to port B.
- All others get REQ_READY=0.
REQ-008 A valid requester whose address equals the port A winner's address SHALL NOT be granted in that cycle.
REQ-009 At most two REQ_READY bits SHALL be 1 in any cycle, and granted port A/B addresses SHALL never be equal.
REQ-010 PTR SHALL advance to (index of last granted requester + 1) mod NUM_REQ after any grant, and remain unchanged when nothing is granted.
REQ-011 The registered port outputs SHALL be loaded every cycle, giving one cycle of latency:
- A granted requester's address/data SHALL appear on its port with W_EN=1 in the cycle after the handshake.
- An ungranted port SHALL present W_EN=0; its ADDR/DATA hold their previous values.
REQ-012 INIT clear sequence:
- In each INIT cycle with counter C, the next cycle SHALL present PORTA_W_ADDR=2C and PORTB_W_ADDR=2C+1, both W_DATA=0, both W_EN=1.
- C SHALL start at 0 on entry to INIT and increment each INIT cycle.
- A full clear SHALL take 2^(ADDR_WIDTH-1) cycles.
REQ-013 An INIT_START arriving in the same cycle as ARB grants SHALL NOT cancel those grants. Their writes issue in the next cycle, and the clear writes follow them.
REQ-014 ERR SHALL be set and held until reset when PORTB_W_CONTENT=1 while PORTB_W_EN=1.
REQ-015 STALL_CNT SHALL increment in each ARB cycle where at least one REQ_VALID bit has REQ_READY=0, and SHALL saturate at 16'hFFFF.
REQ-016 Requesters SHALL hold REQ_ADDR/REQ_DATA stable while REQ_VALID=1 and ungranted. The block SHALL NOT buffer ungranted requests.

Reset
REQ-017 While ARESET=1 at a rising edge, the block SHALL reset as follows:
- State = ARB; PTR = 0; C = 0.
- PORTA/PORTB W_EN = 0 and W_ADDR/W_DATA = 0.
- ERR = 0; STALL_CNT = 0.
REQ-018 REQ_READY SHALL be all 0 while ARESET=1.
REQ-019 Reset asserted mid-INIT SHALL abort the clear, with no further port writes after the reset edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios (defaults, PTR=0):
- Conflict-free pair: REQ_VALID=4'b0011, addr0=3, addr1=5 -> READY=0011. Next cycle: PORTA_W_ADDR=3 and PORTB_W_ADDR=5, both EN=1. PTR becomes 2.
- Same-address deferral: REQ_VALID=4'b0011, addr0=addr1=7 -> READY=0001 and STALL_CNT increments. Next cycle, with only req1 valid -> READY=0010 and a port A write to 7. ERR stays 0.
- Round-robin fairness: all four valid with distinct addresses for 4 cycles -> grants {0,1}, {2,3}, {0,1}, {2,3}; PTR alternates 2, 0.
- Clear sequence: INIT_START pulse -> INIT_BUSY=1 for 8 cycles. Port writes cover addresses 0..15 in pairs (0,1) ... (14,15) with data 0. READY=0 throughout.
- Reset mid-INIT: ARESET after 3 clear cycles -> all W_EN=0 from the next edge, state ARB, and INIT_BUSY=0.
- Error flag: force PORTB_W_CONTENT=1 during a port B write -> ERR=1, held until ARESET.

Source files
------------

// File: rtl/dpram_write_sched.sv
// dpram_write_sched: round-robin scheduler feeding two RAM write ports, with a RAM clear sequence
// ACLK/ARESET: clock and synchronous active-high reset
// REQ_*: per-requester write requests, REQ_READY is the combinational grant
// INIT_START/INIT_BUSY: clear request pulse and clear-in-progress flag
// PORTA_W_*/PORTB_W_*: registered RAM write ports, PORTB_W_CONTENT is the RAM conflict flag
// ERR: sticky conflict error, STALL_CNT: saturating count of cycles with an ungranted request
module dpram_write_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REQ    = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          INIT_START,
  output logic                          INIT_BUSY,
  output logic [ADDR_WIDTH-1:0]         PORTA_W_ADDR,
  output logic [DATA_WIDTH-1:0]         PORTA_W_DATA,
  output logic                          PORTA_W_EN,
  output logic [ADDR_WIDTH-1:0]         PORTB_W_ADDR,
  output logic [DATA_WIDTH-1:0]         PORTB_W_DATA,
  output logic                          PORTB_W_EN,
  input  logic                          PORTB_W_CONTENT,
  output logic                          ERR,
  output logic [15:0]                   STALL_CNT
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = ADDR_WIDTH > 1 ? ADDR_WIDTH - 1 : 1;
  localparam logic [CW-1:0] C_LAST = CW'((1 << (ADDR_WIDTH - 1)) - 1);
  typedef enum logic {ARB, INIT} state_e;
  state_e state_q;
  logic [PW-1:0] ptr_q, ptr_d, ia, ib;
  logic [CW-1:0] c_q;
  logic ga, gb, grant_en;
  logic [NUM_REQ-1:0] rdy;
  logic [ADDR_WIDTH-1:0] addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr[i] = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data[i] = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
  end
  function automatic logic [PW-1:0] rr(input logic [PW-1:0] p, input int k);
    return PW'((int'(p) + k) % NUM_REQ);
  endfunction
  // port B takes the next valid requester after the port A winner whose address differs
  always_comb begin
    ga = 1'b0;
    gb = 1'b0;
    ia = '0;
    ib = '0;
    rdy = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (REQ_VALID[rr(ptr_q, k)] && !ga) begin
        ga = 1'b1;
        ia = rr(ptr_q, k);
      end else if (REQ_VALID[rr(ptr_q, k)] && !gb && addr[rr(ptr_q, k)] != addr[ia]) begin
        gb = 1'b1;
        ib = rr(ptr_q, k);
      end
    end
    if (ga) rdy[ia] = 1'b1;
    if (gb) rdy[ib] = 1'b1;
    ptr_d = gb ? rr(ib, 1) : rr(ia, 1);
  end
  assign grant_en  = state_q == ARB && !ARESET;
  assign REQ_READY = grant_en ? rdy : '0;
  assign INIT_BUSY = state_q == INIT;
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= ARB;
      ptr_q        <= '0;
      c_q          <= '0;
      PORTA_W_ADDR <= '0;
      PORTA_W_DATA <= '0;
      PORTA_W_EN   <= 1'b0;
      PORTB_W_ADDR <= '0;
      PORTB_W_DATA <= '0;
      PORTB_W_EN   <= 1'b0;
      ERR          <= 1'b0;
      STALL_CNT    <= '0;
    end else begin
      PORTA_W_EN <= 1'b0;
      PORTB_W_EN <= 1'b0;
      if (PORTB_W_CONTENT && PORTB_W_EN) ERR <= 1'b1;
      if (state_q == INIT) begin
        PORTA_W_ADDR <= ADDR_WIDTH'({c_q, 1'b0});
        PORTB_W_ADDR <= ADDR_WIDTH'({c_q, 1'b1});
        PORTA_W_DATA <= '0;
        PORTB_W_DATA <= '0;
        PORTA_W_EN   <= 1'b1;
        PORTB_W_EN   <= 1'b1;
        c_q          <= c_q + 1'b1;
        if (c_q == C_LAST) state_q <= ARB;
      end else begin
        if (ga) begin
          PORTA_W_ADDR <= addr[ia];
          PORTA_W_DATA <= data[ia];
          PORTA_W_EN   <= 1'b1;
          ptr_q        <= ptr_d;
        end
        if (gb) begin
          PORTB_W_ADDR <= addr[ib];
          PORTB_W_DATA <= data[ib];
          PORTB_W_EN   <= 1'b1;
        end
        // grants made alongside INIT_START still issue; the clear follows them
        if (INIT_START) begin
          state_q <= INIT;
          c_q     <= '0;
        end
        if (|(REQ_VALID & ~rdy) && STALL_CNT != 16'hFFFF) STALL_CNT <= STALL_CNT + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_dpram_write_sched.sv
// tb_dpram_write_sched: randomized and directed checks of dpram_write_sched against a behavioural model
module tb_dpram_write_sched;
  localparam int DW = 32, AW = 4, N = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, init_start, init_busy, content, err, a_en, b_en;
  logic [N-1:0] valid, ready;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] data;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic [15:0] stall;
  dpram_write_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
    .ACLK(clk), .ARESET(rst), .REQ_VALID(valid), .REQ_ADDR(addr), .REQ_DATA(data),
    .REQ_READY(ready), .INIT_START(init_start), .INIT_BUSY(init_busy),
    .PORTA_W_ADDR(a_addr), .PORTA_W_DATA(a_data), .PORTA_W_EN(a_en),
    .PORTB_W_ADDR(b_addr), .PORTB_W_DATA(b_data), .PORTB_W_EN(b_en),
    .PORTB_W_CONTENT(content), .ERR(err), .STALL_CNT(stall)
  );
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  bit m_init, m_ae, m_be, m_err;
  int m_c, m_ptr, m_stall, ga, gb, busy_cycles;
  logic [AW-1:0] m_aa, m_ba;
  logic [DW-1:0] m_ad, m_bd;
  function automatic logic [AW-1:0] ad(input int i);
    return addr[i*AW +: AW];
  endfunction
  function automatic logic [DW-1:0] dt(input int i);
    return data[i*DW +: DW];
  endfunction
  task automatic req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW] = a;
    data[i*DW +: DW] = d;
  endtask
  task automatic grants();
    ga = -1;
    gb = -1;
    if (rst || m_init) return;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (valid[i]) begin
        if (ga < 0) ga = i;
        else if (gb < 0 && ad(i) != ad(ga)) gb = i;
      end
    end
  endtask
  task automatic step(input string tag);
    logic [N-1:0] er;
    bit stalled;
    grants();
    er = '0;
    if (ga >= 0) er[ga] = 1'b1;
    if (gb >= 0) er[gb] = 1'b1;
    #3;
    chk({tag, ".ready"}, 64'(ready), 64'(er));
    chk({tag, ".busy"}, 64'(init_busy), 64'(m_init));
    if (init_busy) busy_cycles++;
    stalled = !rst && !m_init && ((valid & ~er) != '0);
    @(posedge clk);
    if (rst) begin
      m_init = 0; m_c = 0; m_ptr = 0; m_stall = 0; m_err = 0;
      m_ae = 0; m_be = 0; m_aa = '0; m_ba = '0; m_ad = '0; m_bd = '0;
    end else begin
      if (content && m_be) m_err = 1;
      if (m_init) begin
        m_aa = AW'(2 * m_c); m_ba = AW'(2 * m_c + 1); m_ad = '0; m_bd = '0;
        m_ae = 1; m_be = 1;
        m_c++;
        if (m_c == (1 << (AW - 1))) begin m_init = 0; m_c = 0; end
      end else begin
        m_ae = ga >= 0;
        m_be = gb >= 0;
        if (ga >= 0) begin m_aa = ad(ga); m_ad = dt(ga); m_ptr = (ga + 1) % N; end
        if (gb >= 0) begin m_ba = ad(gb); m_bd = dt(gb); m_ptr = (gb + 1) % N; end
        if (init_start) begin m_init = 1; m_c = 0; end
        if (stalled && m_stall < 65535) m_stall++;
      end
    end
    #1;
    chk({tag, ".a_en"}, 64'(a_en), 64'(m_ae));
    chk({tag, ".b_en"}, 64'(b_en), 64'(m_be));
    chk({tag, ".a_addr"}, 64'(a_addr), 64'(m_aa));
    chk({tag, ".b_addr"}, 64'(b_addr), 64'(m_ba));
    chk({tag, ".a_data"}, 64'(a_data), 64'(m_ad));
    chk({tag, ".b_data"}, 64'(b_data), 64'(m_bd));
    chk({tag, ".err"}, 64'(err), 64'(m_err));
    chk({tag, ".stall"}, 64'(stall), 64'(m_stall));
  endtask
  task automatic idle();
    valid = '0; init_start = 0; content = 0; rst = 0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    step("rst");
    rst = 0;
  endtask
  initial begin
    rst = 1; valid = '0; addr = '0; data = '0; init_start = 0; content = 0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst.stall0", 64'(stall), 64'd0);
    valid = 4'b0011; req(0, 4'd3, 32'hA0); req(1, 4'd5, 32'hB1);
    step("pair");
    chk("pair.aaddr", 64'(a_addr), 64'd3);
    chk("pair.baddr", 64'(b_addr), 64'd5);
    valid = 4'b0011; req(2, 4'd8, 32'hC2); req(3, 4'd9, 32'hD3);
    valid = 4'b1100;
    step("pair.ptr2");
    do_reset();
    valid = 4'b0011; req(0, 4'd7, 32'h11); req(1, 4'd7, 32'h22);
    step("defer");
    chk("defer.stall", 64'(stall), 64'd1);
    valid = 4'b0010;
    step("defer.req1");
    chk("defer.aaddr", 64'(a_addr), 64'd7);
    chk("defer.err", 64'(err), 64'd0);
    do_reset();
    valid = 4'b1111;
    for (int i = 0; i < N; i++) req(i, AW'(i * 3 + 1), 32'(i + 100));
    for (int r = 0; r < 4; r++) step("rr");
    idle();
    busy_cycles = 0;
    init_start = 1;
    step("init.start");
    init_start = 0;
    for (int i = 0; i < 9; i++) begin
      valid = 4'b0101;
      init_start = i == 2;
      step("init");
    end
    chk("init.cycles", 64'(busy_cycles), 64'd8);
    idle();
    valid = 4'b0011; req(0, 4'd2, 32'h55); req(1, 4'd4, 32'h66);
    init_start = 1;
    step("init.overlap");
    idle();
    for (int i = 0; i < 3; i++) step("init.part");
    rst = 1;
    step("init.abort");
    rst = 0;
    chk("abort.busy", 64'(init_busy), 64'd0);
    step("abort.idle");
    valid = 4'b0011; req(0, 4'd1, 32'h77); req(1, 4'd6, 32'h88);
    content = 1;
    step("err.noen");
    valid = '0;
    step("err.set");
    content = 0;
    for (int i = 0; i < 3; i++) step("err.hold");
    chk("err.held", 64'(err), 64'd1);
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!(valid[i] && ga != i && gb != i)) begin
          valid[i] = $urandom_range(0, 2) != 0;
          req(i, AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 2)), $urandom);
        end
      end
      rst = $urandom_range(0, 99) == 0;
      init_start = $urandom_range(0, 39) == 0;
      content = $urandom_range(0, 15) == 0;
      step("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
